// File: rtl/display_scheduler_if.sv
// Bus between the metronome control logic and the display scheduler.
// master drives requests and live BPM; slave (the scheduler) drives display and commit outputs.
interface display_scheduler_if;
  logic        key_req;
  logic [3:0]  key_val;
  logic        msg_req;
  logic [1:0]  msg_code;
  logic [11:0] bpm_bcd;
  logic        beat;
  logic [3:0]  dig_hi;
  logic [3:0]  dig_mid;
  logic [3:0]  dig_lo;
  logic [1:0]  seg_mode;
  logic [1:0]  msg_out;
  logic [1:0]  owner;
  logic        set_valid;
  logic [11:0] set_bcd;

  modport master (
    output key_req, key_val, msg_req, msg_code, bpm_bcd, beat,
    input  dig_hi, dig_mid, dig_lo, seg_mode, msg_out, owner, set_valid, set_bcd
  );

  modport slave (
    input  key_req, key_val, msg_req, msg_code, bpm_bcd, beat,
    output dig_hi, dig_mid, dig_lo, seg_mode, msg_out, owner, set_valid, set_bcd
  );
endinterface

// File: rtl/display_scheduler.sv
// Display-ownership scheduler (KEY > MSG > BPM) with keypad BPM entry buffer.
// Optional beat blinking of the BPM readout is enabled by defining DISP_SCHED_BLINK_EN.
module display_scheduler #(
  parameter int HOLD_KEY     = 100_000_000,
  parameter int HOLD_MSG     = 50_000_000,
  parameter int BLINK_CYCLES = 10_000_000,
  parameter int CNT_W        = 27
) (
  input  logic clk,
  input  logic rst,
  display_scheduler_if.slave bus
);

  typedef enum logic [1:0] {ST_BPM = 2'b00, ST_KEY = 2'b01, ST_MSG = 2'b10} stateT;

  localparam logic [1:0] MODE_DIGITS = 2'b00;
  localparam logic [1:0] MODE_MSG    = 2'b01;
  localparam logic [1:0] MODE_DASH   = 2'b10;
  // Counters expire when they reach zero, so loading N-1 gives exactly N cycles of ownership.
  localparam logic [CNT_W-1:0] KEY_LOAD = CNT_W'(HOLD_KEY - 1);
  localparam logic [CNT_W-1:0] MSG_LOAD = CNT_W'(HOLD_MSG - 1);

  stateT            stateReg, stateNext;
  logic [CNT_W-1:0] holdReg, holdNext;
  logic [1:0]       codeReg, codeNext;
  logic             pendReg, pendNext;
  logic [1:0]       pendCodeReg, pendCodeNext;
  logic [3:0]       bufHiReg, bufHiNext, bufMidReg, bufMidNext, bufLoReg, bufLoNext;
  logic [1:0]       bufCntReg, bufCntNext;
  logic             setPulseReg, setPulseNext;
  logic [11:0]      setBcdReg, setBcdNext;

  logic [3:0]  digHiReg, digHiNext, digMidReg, digMidNext, digLoReg, digLoNext;
  logic [1:0]  segModeReg, segModeNext, msgOutReg, msgOutNext, ownerReg, ownerNext;
  logic        setValidReg, setValidNext;
  logic [11:0] setBcdOutReg, setBcdOutNext;

  logic       keyDigit, keyEnter, keyClear, keyAccept, commit;
  logic       pendEff;
  logic [1:0] pendCodeEff;
  logic [11:0] entryBcd;
  logic [1:0] bpmMode;

  assign keyDigit  = bus.key_req && (bus.key_val <= 4'd9);
  assign keyEnter  = bus.key_req && (bus.key_val == 4'hE);
  assign keyClear  = bus.key_req && (bus.key_val == 4'hF);
  assign keyAccept = keyDigit || keyEnter || keyClear;
  assign commit    = keyEnter && (bufCntReg != 2'd0);

`ifdef DISP_SCHED_BLINK_EN
  logic [CNT_W-1:0] blinkReg, blinkNext;

  always_comb begin
    blinkNext = blinkReg;
    if (bus.beat) begin
      blinkNext = CNT_W'(BLINK_CYCLES);
    end else if (blinkReg != '0) begin
      blinkNext = blinkReg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blinkReg <= '0;
    end else begin
      blinkReg <= blinkNext;
    end
  end

  assign bpmMode = (blinkReg != '0) ? MODE_DIGITS : MODE_DASH;
`else
  logic unusedBeat;
  assign unusedBeat = bus.beat;
  assign bpmMode    = MODE_DIGITS;
`endif

  always_comb begin
    case (bufCntReg)
      2'd1:    entryBcd = {8'h00, bufLoReg};
      2'd2:    entryBcd = {4'h0, bufMidReg, bufLoReg};
      2'd3:    entryBcd = {bufHiReg, bufMidReg, bufLoReg};
      default: entryBcd = 12'h000;
    endcase
  end

  // Next-state logic: FSM, hold counter, pending message and entry buffer.
  always_comb begin
    stateNext    = stateReg;
    holdNext     = holdReg;
    codeNext     = codeReg;
    pendNext     = pendReg;
    pendCodeNext = pendCodeReg;
    bufHiNext    = bufHiReg;
    bufMidNext   = bufMidReg;
    bufLoNext    = bufLoReg;
    bufCntNext   = bufCntReg;
    setPulseNext = 1'b0;
    setBcdNext   = setBcdReg;

    // A key event preempts the shown message; a message arriving alongside keys waits.
    pendEff     = pendReg;
    pendCodeEff = pendCodeReg;
    if (keyAccept && (stateReg == ST_MSG)) begin
      pendEff     = 1'b1;
      pendCodeEff = codeReg;
    end
    if (bus.msg_req && (keyAccept || (stateReg == ST_KEY))) begin
      pendEff     = 1'b1;
      pendCodeEff = bus.msg_code;
    end

    if (keyDigit) begin
      bufHiNext  = bufMidReg;
      bufMidNext = bufLoReg;
      bufLoNext  = bus.key_val;
      if (bufCntReg != 2'd3) begin
        bufCntNext = bufCntReg + 2'd1;
      end
    end else if (keyClear || commit) begin
      bufHiNext  = 4'h0;
      bufMidNext = 4'h0;
      bufLoNext  = 4'h0;
      bufCntNext = 2'd0;
    end

    if (commit) begin
      setPulseNext = 1'b1;
      setBcdNext   = entryBcd;
      pendNext     = 1'b0;
      if (pendEff) begin
        stateNext = ST_MSG;
        codeNext  = pendCodeEff;
        holdNext  = MSG_LOAD;
      end else begin
        stateNext = ST_BPM;
      end
    end else if (keyAccept) begin
      stateNext    = ST_KEY;
      holdNext     = KEY_LOAD;
      pendNext     = pendEff;
      pendCodeNext = pendCodeEff;
    end else begin
      case (stateReg)
        ST_KEY: begin
          pendNext     = pendEff;
          pendCodeNext = pendCodeEff;
          if (holdReg == '0) begin
            if (pendEff) begin
              stateNext = ST_MSG;
              codeNext  = pendCodeEff;
              holdNext  = MSG_LOAD;
              pendNext  = 1'b0;
            end else begin
              stateNext = ST_BPM;
            end
          end else begin
            holdNext = holdReg - 1'b1;
          end
        end
        ST_MSG: begin
          if (bus.msg_req) begin
            codeNext = bus.msg_code;
            holdNext = MSG_LOAD;
          end else if (holdReg == '0) begin
            stateNext = ST_BPM;
          end else begin
            holdNext = holdReg - 1'b1;
          end
        end
        default: begin
          if (bus.msg_req) begin
            stateNext = ST_MSG;
            codeNext  = bus.msg_code;
            holdNext  = MSG_LOAD;
          end
        end
      endcase
    end
  end

  // Output decode from the current owner; registered below for glitch-free display.
  always_comb begin
    ownerNext     = stateReg;
    segModeNext   = bpmMode;
    msgOutNext    = 2'b00;
    digHiNext     = bus.bpm_bcd[11:8];
    digMidNext    = bus.bpm_bcd[7:4];
    digLoNext     = bus.bpm_bcd[3:0];
    setValidNext  = setPulseReg;
    setBcdOutNext = setBcdReg;
    case (stateReg)
      ST_KEY: begin
        segModeNext = MODE_DIGITS;
        digHiNext   = (bufCntReg == 2'd3) ? bufHiReg : 4'hA;
        digMidNext  = (bufCntReg >= 2'd2) ? bufMidReg : 4'hA;
        digLoNext   = (bufCntReg >= 2'd1) ? bufLoReg : 4'hA;
      end
      ST_MSG: begin
        segModeNext = MODE_MSG;
        msgOutNext  = codeReg;
        digHiNext   = 4'h0;
        digMidNext  = 4'h0;
        digLoNext   = 4'h0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg     <= ST_BPM;
      holdReg      <= '0;
      codeReg      <= 2'b00;
      pendReg      <= 1'b0;
      pendCodeReg  <= 2'b00;
      bufHiReg     <= 4'h0;
      bufMidReg    <= 4'h0;
      bufLoReg     <= 4'h0;
      bufCntReg    <= 2'd0;
      setPulseReg  <= 1'b0;
      setBcdReg    <= 12'h000;
      digHiReg     <= 4'h0;
      digMidReg    <= 4'h0;
      digLoReg     <= 4'h0;
      segModeReg   <= MODE_DASH;
      msgOutReg    <= 2'b00;
      ownerReg     <= ST_BPM;
      setValidReg  <= 1'b0;
      setBcdOutReg <= 12'h000;
    end else begin
      stateReg     <= stateNext;
      holdReg      <= holdNext;
      codeReg      <= codeNext;
      pendReg      <= pendNext;
      pendCodeReg  <= pendCodeNext;
      bufHiReg     <= bufHiNext;
      bufMidReg    <= bufMidNext;
      bufLoReg     <= bufLoNext;
      bufCntReg    <= bufCntNext;
      setPulseReg  <= setPulseNext;
      setBcdReg    <= setBcdNext;
      digHiReg     <= digHiNext;
      digMidReg    <= digMidNext;
      digLoReg     <= digLoNext;
      segModeReg   <= segModeNext;
      msgOutReg    <= msgOutNext;
      ownerReg     <= ownerNext;
      setValidReg  <= setValidNext;
      setBcdOutReg <= setBcdOutNext;
    end
  end

  assign bus.dig_hi    = digHiReg;
  assign bus.dig_mid   = digMidReg;
  assign bus.dig_lo    = digLoReg;
  assign bus.seg_mode  = segModeReg;
  assign bus.msg_out   = msgOutReg;
  assign bus.owner     = ownerReg;
  assign bus.set_valid = setValidReg;
  assign bus.set_bcd   = setBcdOutReg;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed table-driven bench for display_scheduler (HOLD_KEY=8, HOLD_MSG=4, BLINK_CYCLES=3).
// Each row: inputs applied before an edge, outputs compared 1 ns after it.
module tb_display_scheduler;
  localparam int HK = 8;
  localparam int HM = 4;
  localparam int BC = 3;
`ifdef DISP_SCHED_BLINK_EN
  localparam logic [1:0] BPM_MODE = 2'b10;
`else
  localparam logic [1:0] BPM_MODE = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  display_scheduler_if dif ();

  display_scheduler #(
    .HOLD_KEY(HK), .HOLD_MSG(HM), .BLINK_CYCLES(BC), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  // Packed expectation: {owner, seg_mode, dig_hi, dig_mid, dig_lo, msg_out, set_valid, set_bcd}
  typedef struct {
    logic        r;
    logic        kr;
    logic [3:0]  kv;
    logic        mr;
    logic [1:0]  mc;
    logic        bt;
    logic [30:0] e;
  } vecT;

  vecT         vecs[$];
  int          passed = 0;
  int          total  = 0;
  logic [11:0] sbExp  = 12'h000;
  logic [30:0] act;

  assign act = {dif.owner, dif.seg_mode, dif.dig_hi, dif.dig_mid, dif.dig_lo,
                dif.msg_out, dif.set_valid, dif.set_bcd};

  function automatic logic [30:0] pk(logic [1:0] ow, logic [1:0] md, logic [11:0] dg,
                                     logic [1:0] mo, logic sv, logic [11:0] sb);
    return {ow, md, dg, mo, sv, sb};
  endfunction

  function logic [30:0] eB(logic sv);
    return pk(2'd0, BPM_MODE, 12'h120, 2'd0, sv, sbExp);
  endfunction

  function logic [30:0] eK(logic [11:0] dg);
    return pk(2'd1, 2'd0, dg, 2'd0, 1'b0, sbExp);
  endfunction

  function logic [30:0] eM(logic [1:0] code);
    return pk(2'd2, 2'd1, 12'h000, code, 1'b0, sbExp);
  endfunction

  function void add(logic r, logic kr, logic [3:0] kv, logic mr, logic [1:0] mc,
                    logic bt, logic [30:0] e);
    vecT v;
    v.r = r; v.kr = kr; v.kv = kv; v.mr = mr; v.mc = mc; v.bt = bt; v.e = e;
    vecs.push_back(v);
  endfunction

  function void key(logic [3:0] kv, logic [30:0] e);
    add(1'b0, 1'b1, kv, 1'b0, 2'd0, 1'b0, e);
  endfunction

  function void msg(logic [1:0] mc, logic [30:0] e);
    add(1'b0, 1'b0, 4'h0, 1'b1, mc, 1'b0, e);
  endfunction

  function void idle(logic [30:0] e);
    add(1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, e);
  endfunction

  task automatic drive(logic r, logic kr, logic [3:0] kv, logic mr, logic [1:0] mc, logic bt);
    rst          = r;
    dif.key_req  = kr;
    dif.key_val  = kv;
    dif.msg_req  = mr;
    dif.msg_code = mc;
    dif.beat     = bt;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [30:0] e);
    total++;
    $display("%s: owner=%0d mode=%0d dig=%h%h%h msg=%0d set_valid=%0b set_bcd=%h",
             nm, dif.owner, dif.seg_mode, dif.dig_hi, dif.dig_mid, dif.dig_lo,
             dif.msg_out, dif.set_valid, dif.set_bcd);
    if (act === e) begin
      passed++;
    end else begin
      $display("FAIL %s actual=%h required=%h", nm, act, e);
    end
  endtask

  initial begin
    dif.bpm_bcd = 12'h120;
    drive(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
    chk("reset_state", pk(2'd0, 2'd2, 12'h000, 2'd0, 1'b0, 12'h000));

    // Release reset, then keys 1,2,0,E
    idle(eB(1'b0));
    key(4'h1, eB(1'b0));
    key(4'h2, eK(12'hAA1));
    key(4'h0, eK(12'hA12));
    key(4'hE, eK(12'h120));
    sbExp = 12'h120;
    idle(eB(1'b1));
    // 7,E then 1,2,3,4,E (oldest digit lost)
    key(4'h7, eB(1'b0));
    key(4'hE, eK(12'hAA7));
    sbExp = 12'h007;
    key(4'h1, eB(1'b1));
    key(4'h2, eK(12'hAA1));
    key(4'h3, eK(12'hA12));
    key(4'h4, eK(12'h123));
    key(4'hE, eK(12'h234));
    sbExp = 12'h234;
    idle(eB(1'b1));
    // E on empty buffer: KEY for exactly 8 cycles, no commit
    key(4'hE, eB(1'b0));
    for (int i = 0; i < HK; i++) idle(eK(12'hAAA));
    idle(eB(1'b0));
    // A-D ignored
    key(4'hB, eB(1'b0));
    idle(eB(1'b0));
    // Message REC for 4 cycles
    msg(2'd0, eB(1'b0));
    for (int i = 0; i < HM; i++) idle(eM(2'd0));
    idle(eB(1'b0));
    // REC then ERR two cycles later extends hold
    msg(2'd0, eB(1'b0));
    idle(eM(2'd0));
    msg(2'd2, eM(2'd0));
    for (int i = 0; i < HM; i++) idle(eM(2'd2));
    idle(eB(1'b0));
    // Simultaneous key 5 and PLAY: KEY 8, then MSG PLAY 4, then BPM
    add(1'b0, 1'b1, 4'h5, 1'b1, 2'd1, 1'b0, eB(1'b0));
    for (int i = 0; i < HK; i++) idle(eK(12'hAA5));
    for (int i = 0; i < HM; i++) idle(eM(2'd1));
    idle(eB(1'b0));
    // Buffer survived KEY expiry: E commits 005 from BPM
    key(4'hE, eB(1'b0));
    sbExp = 12'h005;
    idle(eB(1'b1));
    // Key during MSG DONE: DONE becomes pending and returns after KEY
    msg(2'd3, eB(1'b0));
    idle(eM(2'd3));
    key(4'h9, eM(2'd3));
    for (int i = 0; i < HK; i++) idle(eK(12'hAA9));
    for (int i = 0; i < HM; i++) idle(eM(2'd3));
    idle(eB(1'b0));
    // F clears, then commit with pending ERR goes straight to MSG
    key(4'hF, eB(1'b0));
    key(4'h1, eK(12'hAAA));
    msg(2'd2, eK(12'hAA1));
    key(4'hE, eK(12'hAA1));
    sbExp = 12'h001;
    idle(pk(2'd2, 2'd1, 12'h000, 2'd2, 1'b1, sbExp));
    for (int i = 0; i < HM - 1; i++) idle(eM(2'd2));
    idle(eB(1'b0));
    // Beat: 3 cycles of DIGITS when blinking is built in
    add(1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, eB(1'b0));
    for (int i = 0; i < BC; i++) idle(pk(2'd0, 2'd0, 12'h120, 2'd0, 1'b0, sbExp));
    idle(eB(1'b0));
    idle(eB(1'b0));

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].kr, vecs[i].kv, vecs[i].mr, vecs[i].mc, vecs[i].bt);
      chk($sformatf("row%0d", i), vecs[i].e);
    end

    // Reset mid-entry with two digits buffered: all state discarded, later E commits nothing
    drive(1'b0, 1'b1, 4'h3, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 1'b1, 4'h4, 1'b0, 2'd0, 1'b0);
    chk("entry_before_rst", eK(12'hAA3));
    drive(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
    sbExp = 12'h000;
    chk("rst_mid_entry", pk(2'd0, 2'd2, 12'h000, 2'd0, 1'b0, 12'h000));
    drive(1'b0, 1'b1, 4'hE, 1'b0, 2'd0, 1'b0);
    chk("post_rst_bpm", eB(1'b0));
    drive(1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
    chk("post_rst_e_key", eK(12'hAAA));
    drive(1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
    chk("post_rst_no_set", eK(12'hAAA));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
